hs32_alu_arb: RTL
=================

Name: hs32_alu_arb

Overview:
Shares the single combinational hs32_alu between two requesters: port 0 is the execute stage and port 1 is the address/interrupt unit. The block does round-robin arbitration, drives the ALU from the granted request, and registers the result and nzcv flags in a one-entry response buffer. It also owns the architectural flags register, which feeds i_fl of the ALU. It sits between the decode/execute control and the ALU instance inside the CPU core.

Parameters:
MUL_LAT, 4, cycles a multiply occupies the ALU (used only with HS32_ALU_MUL_EN); legal range 2..15.

Ports:
i_clk  in  1  core clock; all state updates on the rising edge
i_reset  in  1  asynchronous, active-high reset
i_req_valid  in  2  per-port request valid (bit n = port n)
o_req_ready  out  2  per-port request accepted this cycle
i_a0, i_b0  in  32 each  port 0 operands
i_op0  in  4  port 0 opcode (HS32A_* encoding)
i_flwe0  in  1  port 0 request updates the flags register
i_a1, i_b1, i_op1, i_flwe1  in  32/32/4/1  port 1 equivalents
o_rsp_valid  out  2  one-hot: response pending for port n
i_rsp_ready  in  2  port n consumes its response
o_rsp_r  out  32  registered result
o_rsp_fl  out  4  registered nzcv produced by the op
o_flags  out  4  architectural flags register (nzcv)
o_busy  out  1  response buffer occupied or multiply in progress

Behaviour:
- Reset (async): o_rsp_valid=0, o_rsp_r=0, o_rsp_fl=0, o_flags=0, rr pointer=0 (port 0 has priority), state=IDLE, o_req_ready=0, o_busy=0.
- The buffer can accept when it is empty, or when the held response is consumed in the same cycle (i_rsp_ready matches the o_rsp_valid bit). Back-to-back operation gives one op per cycle.
- Grant:
  - With one valid request: that port wins.
  - With both valid: the rr pointer port wins, then the pointer flips to the other port.
  - The pointer changes only on a grant.
  - o_req_ready is combinational: it is one-hot for the granted port, and only when the buffer can accept.
- The ALU is driven combinationally from the granted port's operands and opcode, with i_fl=o_flags.
- Latency: on the accept edge, o_rsp_r and o_rsp_fl load from the ALU, and o_rsp_valid sets the granted port's bit. Latency is one cycle.
- Flags: if the granted flwe=1, o_flags loads the ALU o_fl on the accept edge. The next granted op sees the updated flags, so no extra forwarding is needed.
- The response holds stable until consumed. i_rsp_ready on a port with no pending response is ignored.
- Requesters must hold their operands until ready. A request dropped before ready is simply lost, with no state change.
- State machine:
  - IDLE: buffer empty.
  - HOLD: response pending.
  - MUL: multiply running (feature only).
  - IDLE→HOLD on accept. HOLD→IDLE on consume with no new accept. HOLD→HOLD on consume plus accept.
- Widths: operands and results are 32-bit. Carry comes from the ALU's 33rd bit; no extension is done here.

Optional Feature:
HS32_ALU_MUL_EN:
- Defined: the ALU is built with IMUL. An accepted HS32A_MUL enters state MUL with a 4-bit down-counter loaded with MUL_LAT-1, and o_busy=1.
- No requests are accepted until the counter reaches 0. The product then loads the response buffer, giving latency MUL_LAT.
- Operands are latched at accept, so requesters may change them afterwards.
- Reset during MUL aborts the multiply; no response and no flag update.
- Undefined: HS32A_MUL is handled like any other opcode (the ALU default passes b through), with one-cycle latency and no MUL state.

Decomposition:
- Opcodes come from the existing hs32_aluops include.
- A shared include holds the state encodings (HS32ARB_IDLE/HOLD/MUL) and the port index constants.
- One sub-module fits naturally: hs32_rr_arb2, a two-requester round-robin grant with pointer, reusable by the memory arbiter.
- The ALU stays instantiated inside hs32_alu_arb.

Test Plan:
- Port 0: ADD a=5, b=3, flwe=1. Expect o_req_ready=01 the same cycle; next cycle o_rsp_valid=01, o_rsp_r=8, o_rsp_fl=0000, o_flags=0000.
- Port 1: SUB a=3, b=5, flwe=1. Expect o_rsp_r=0xFFFFFFFE, nzcv=1010, o_flags=1010. Then ADC 1+1 with flwe=0 gives r=3 and o_flags unchanged.
- Both ports valid for 4 cycles, responses consumed immediately. Expect grants 0,1,0,1 and a result every cycle.
- Response held with i_rsp_ready=0 for 3 cycles. Expect o_req_ready=00, the response stable, and o_busy=1. Consume plus a new request in the same cycle is accepted.
- Assert i_reset mid-HOLD. All outputs clear immediately (asynchronously), and the rr pointer returns to 0.
- With HS32_ALU_MUL_EN and MUL_LAT=4: MUL 7×6 gives 42 after 4 cycles. A port 1 request is held off until completion.

Source files
------------

// File: rtl/hs32_alu_arb_pkg.sv
// Shared definitions for the hs32 ALU arbiter: ALU opcodes, arbiter states and port indices.
// HS32A_MUL is only meaningful when the build defines HS32_ALU_MUL_EN.
package hs32_alu_arb_pkg;

  localparam logic [3:0] HS32A_ADD = 4'h0;
  localparam logic [3:0] HS32A_ADC = 4'h1;
  localparam logic [3:0] HS32A_SUB = 4'h2;
  localparam logic [3:0] HS32A_SBC = 4'h3;
  localparam logic [3:0] HS32A_AND = 4'h4;
  localparam logic [3:0] HS32A_OR  = 4'h5;
  localparam logic [3:0] HS32A_XOR = 4'h6;
  localparam logic [3:0] HS32A_BIC = 4'h7;
  localparam logic [3:0] HS32A_SHL = 4'h8;
  localparam logic [3:0] HS32A_SHR = 4'h9;
  localparam logic [3:0] HS32A_MUL = 4'hA;

  localparam logic [1:0] HS32ARB_IDLE = 2'd0;
  localparam logic [1:0] HS32ARB_HOLD = 2'd1;
  localparam logic [1:0] HS32ARB_MUL  = 2'd2;

  localparam int HS32ARB_P0 = 0;
  localparam int HS32ARB_P1 = 1;

  // Flag vector layout is {n, z, c, v}.
  localparam int HS32_FL_C = 1;

endpackage

// File: rtl/hs32_alu.sv
// Combinational hs32 ALU: 32-bit result plus nzcv, carry taken from the 33rd sum bit.
// IMUL is only built when HS32_ALU_MUL_EN is defined; otherwise HS32A_MUL passes b through.
module hs32_alu
  import hs32_alu_arb_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_fl,
  output logic [31:0] o_r,
  output logic [3:0]  o_fl
);

  logic [32:0] sum;
  logic        c;
  logic        v;
  logic        unused_fl;

  assign unused_fl = ^{i_fl[3:2], i_fl[0]};

  always_comb begin
    sum = 33'd0;
    o_r = i_b;
    c   = 1'b0;
    v   = 1'b0;
    case (i_op)
      HS32A_ADD, HS32A_ADC: begin
        sum = {1'b0, i_a} + {1'b0, i_b};
        if (i_op == HS32A_ADC) sum = sum + {32'd0, i_fl[HS32_FL_C]};
        o_r = sum[31:0];
        c   = sum[32];
        v   = (i_a[31] == i_b[31]) && (o_r[31] != i_a[31]);
      end
      // Subtract carry is a borrow: set when b (plus borrow-in) exceeds a.
      HS32A_SUB, HS32A_SBC: begin
        sum = {1'b0, i_a} - {1'b0, i_b};
        if (i_op == HS32A_SBC) sum = sum - {32'd0, i_fl[HS32_FL_C]};
        o_r = sum[31:0];
        c   = sum[32];
        v   = (i_a[31] != i_b[31]) && (o_r[31] != i_a[31]);
      end
      HS32A_AND: o_r = i_a & i_b;
      HS32A_OR:  o_r = i_a | i_b;
      HS32A_XOR: o_r = i_a ^ i_b;
      HS32A_BIC: o_r = i_a & ~i_b;
      HS32A_SHL: o_r = i_a << i_b[4:0];
      HS32A_SHR: o_r = i_a >> i_b[4:0];
`ifdef HS32_ALU_MUL_EN
      HS32A_MUL: o_r = i_a * i_b;
`endif
      default:   o_r = i_b;
    endcase
  end

  assign o_fl = {o_r[31], (o_r == 32'd0), c, v};

endmodule

// File: rtl/hs32_rr_arb2.sv
// Two-requester round-robin grant; the pointer moves past the winner on every grant.
module hs32_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = ptr_q ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
    end
    ptr_d = ptr_q;
    if (o_gnt[0])      ptr_d = 1'b1;
    else if (o_gnt[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hs32_alu_arb.sv
// Round-robin sharing of one hs32_alu between execute (port 0) and addr/irq (port 1),
// with a one-entry response buffer and the architectural flags. HS32_ALU_MUL_EN adds multi-cycle IMUL.
module hs32_alu_arb
  import hs32_alu_arb_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [31:0] i_a0,
  input  logic [31:0] i_b0,
  input  logic [3:0]  i_op0,
  input  logic        i_flwe0,
  input  logic [31:0] i_a1,
  input  logic [31:0] i_b1,
  input  logic [3:0]  i_op1,
  input  logic        i_flwe1,
  output logic [1:0]  o_rsp_valid,
  input  logic [1:0]  i_rsp_ready,
  output logic [31:0] o_rsp_r,
  output logic [3:0]  o_rsp_fl,
  output logic [3:0]  o_flags,
  output logic        o_busy
);

  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("hs32_alu_arb: MUL_LAT must be within 2..15");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_r_q, rsp_r_d;
  logic [3:0]  rsp_fl_q, rsp_fl_d;
  logic [3:0]  flags_q, flags_d;

  logic        consume;
  logic        can_accept;
  logic [1:0]  gnt;
  logic        accept;
  logic        mul_start;
  logic [31:0] sel_a, sel_b;
  logic [3:0]  sel_op;
  logic        sel_flwe;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_r;
  logic [3:0]  alu_fl;

  assign consume    = |(i_rsp_ready & rsp_valid_q);
  assign can_accept = (state_q == HS32ARB_IDLE) || ((state_q == HS32ARB_HOLD) && consume);

  hs32_rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (i_req_valid),
    .i_en    (can_accept),
    .o_gnt   (gnt)
  );

  assign accept   = |gnt;
  assign sel_a    = gnt[HS32ARB_P1] ? i_a1 : i_a0;
  assign sel_b    = gnt[HS32ARB_P1] ? i_b1 : i_b0;
  assign sel_op   = gnt[HS32ARB_P1] ? i_op1 : i_op0;
  assign sel_flwe = gnt[HS32ARB_P1] ? i_flwe1 : i_flwe0;

`ifdef HS32_ALU_MUL_EN
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic [1:0]  mul_port_q, mul_port_d;
  logic        mul_flwe_q, mul_flwe_d;
  logic        in_mul;

  assign in_mul    = (state_q == HS32ARB_MUL);
  assign mul_start = accept && (sel_op == HS32A_MUL);
  // While multiplying, the ALU sees the operands captured at accept, not the live ports.
  assign alu_a     = in_mul ? mul_a_q : sel_a;
  assign alu_b     = in_mul ? mul_b_q : sel_b;
  assign alu_op    = in_mul ? HS32A_MUL : sel_op;
`else
  assign mul_start = 1'b0;
  assign alu_a     = sel_a;
  assign alu_b     = sel_b;
  assign alu_op    = sel_op;
`endif

  hs32_alu u_alu (
    .i_op (alu_op),
    .i_a  (alu_a),
    .i_b  (alu_b),
    .i_fl (flags_q),
    .o_r  (alu_r),
    .o_fl (alu_fl)
  );

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_r_d     = rsp_r_q;
    rsp_fl_d    = rsp_fl_q;
    flags_d     = flags_q;
`ifdef HS32_ALU_MUL_EN
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_port_d  = mul_port_q;
    mul_flwe_d  = mul_flwe_q;
`endif
    case (state_q)
      HS32ARB_IDLE, HS32ARB_HOLD: begin
        if (consume) begin
          rsp_valid_d = 2'b00;
          state_d     = HS32ARB_IDLE;
        end
        if (accept && !mul_start) begin
          rsp_valid_d = gnt;
          rsp_r_d     = alu_r;
          rsp_fl_d    = alu_fl;
          if (sel_flwe) flags_d = alu_fl;
          state_d     = HS32ARB_HOLD;
        end
`ifdef HS32_ALU_MUL_EN
        if (mul_start) begin
          state_d    = HS32ARB_MUL;
          cnt_d      = MUL_CNT_INIT;
          mul_a_d    = sel_a;
          mul_b_d    = sel_b;
          mul_port_d = gnt;
          mul_flwe_d = sel_flwe;
        end
`endif
      end
`ifdef HS32_ALU_MUL_EN
      // Count 1 -> 0 is the completing edge, giving MUL_LAT cycles from accept to response.
      HS32ARB_MUL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_valid_d = mul_port_q;
          rsp_r_d     = alu_r;
          rsp_fl_d    = alu_fl;
          if (mul_flwe_q) flags_d = alu_fl;
          state_d     = HS32ARB_HOLD;
        end
      end
`endif
      default: state_d = HS32ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= HS32ARB_IDLE;
      rsp_valid_q <= 2'b00;
      rsp_r_q     <= 32'd0;
      rsp_fl_q    <= 4'd0;
      flags_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      rsp_fl_q    <= rsp_fl_d;
      flags_q     <= flags_d;
    end
  end

`ifdef HS32_ALU_MUL_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q      <= 4'd0;
      mul_a_q    <= 32'd0;
      mul_b_q    <= 32'd0;
      mul_port_q <= 2'b00;
      mul_flwe_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_port_q <= mul_port_d;
      mul_flwe_q <= mul_flwe_d;
    end
  end
`endif

  assign o_req_ready = gnt;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_r     = rsp_r_q;
  assign o_rsp_fl    = rsp_fl_q;
  assign o_flags     = flags_q;
  assign o_busy      = (|rsp_valid_q) || (state_q == HS32ARB_MUL);

endmodule
